// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_hs transmitter between four byte requesters.
// Latency: req seen in IDLE at cycle t -> uart_send/ack at t+1; sends spaced >= BYTE_CYCLES.
// Backpressure: requesters hold req level until ack; req is ignored while the pacing window runs.
module uart_tx_arb #(
   parameter int BYTE_CYCLES = 4340
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [3:0] req,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic [7:0] data2,
   input  logic [7:0] data3,
   output logic [3:0] ack,
   output logic       uart_send,
   output logic [7:0] uart_data_in,
   output logic       busy,
   output logic [1:0] last_grant
);

   localparam int CW = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
   // Window covers the send cycle plus BYTE_CYCLES-1 WAIT cycles in total, so that
   // the IDLE cycle which samples req for the next grant lands exactly BYTE_CYCLES after
   // the previous grant.
   localparam logic [CW-1:0] CNT_LOAD = CW'(BYTE_CYCLES - 2);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [1:0]    lg_q, lg_d;
   logic [3:0]    ack_q, ack_d;
   logic          send_q, send_d;
   logic [7:0]    data_q, data_d;

   logic [1:0]    gnt;
   logic [1:0]    idx;
   logic [7:0]    data_sel;

   // Round-robin pick: first set req bit scanning from ptr upward, modulo 4.
   always_comb begin
      gnt = ptr_q;
      idx = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr_q + 2'(k);
         if (req[idx]) begin
            gnt = idx;
         end
      end
   end

   // Byte offered by the chosen requester, sampled in the grant cycle.
   always_comb begin
      case (gnt)
         2'd0:    data_sel = data0;
         2'd1:    data_sel = data1;
         2'd2:    data_sel = data2;
         default: data_sel = data3;
      endcase
   end

   // Next-state: grant in IDLE, count down the pacing window in WAIT.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      lg_d    = lg_q;
      ack_d   = 4'b0000;
      send_d  = 1'b0;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               send_d  = 1'b1;
               ack_d   = 4'b0001 << gnt;
               data_d  = data_sel;
               ptr_d   = gnt + 2'd1;
               lg_d    = gnt;
               cnt_d   = CNT_LOAD;
               state_d = ST_WAIT;
            end
         end
         default: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= 2'd0;
         lg_q    <= 2'd0;
         ack_q   <= 4'b0000;
         send_q  <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         lg_q    <= lg_d;
         ack_q   <= ack_d;
         send_q  <= send_d;
         data_q  <= data_d;
      end
   end

   assign ack          = ack_q;
   assign uart_send    = send_q;
   assign uart_data_in = data_q;
   assign last_grant   = lg_q;
   assign busy         = (state_q == ST_WAIT);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with an 8-cycle pacing window.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Every wait on the DUT is bounded by a cycle budget.
module tb_uart_tx_arb;

   localparam int BC = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
   logic [3:0] ack;
   logic       send;
   logic [7:0] dout;
   logic       busy;
   logic [1:0] lg;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_arb #(.BYTE_CYCLES(BC)) dut (
      .sys_clk      (clk),
      .sys_rst      (rst),
      .req          (req),
      .data0        (d0),
      .data1        (d1),
      .data2        (d2),
      .data3        (d3),
      .ack          (ack),
      .uart_send    (send),
      .uart_data_in (dout),
      .busy         (busy),
      .last_grant   (lg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Steps until uart_send is seen (or the budget runs out); n = edges taken.
   task automatic wait_send(input int maxc, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (send !== 1'b1 && n < maxc);
      chk("send_seen", {31'd0, send}, 32'd1);
   endtask

   initial begin
      int n;
      int sends;
      int acks;
      logic [1:0] exp_port;

      // Reset state
      do_reset();
      chk("rst_send", {31'd0, send}, 32'd0);
      chk("rst_ack",  {28'd0, ack},  32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data", {24'd0, dout}, 32'd0);
      chk("rst_lg",   {30'd0, lg},   32'd0);

      // 1: single request from port 0
      req = 4'b0001; d0 = 8'h11;
      step();
      chk("t1_send", {31'd0, send}, 32'd1);
      chk("t1_data", {24'd0, dout}, 32'h11);
      chk("t1_ack",  {28'd0, ack},  32'b0001);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_lg",   {30'd0, lg},   32'd0);
      req = 4'b0000;
      step();
      chk("t1_send_low", {31'd0, send}, 32'd0);
      chk("t1_ack_low",  {28'd0, ack},  32'd0);
      for (int i = 0; i < 5; i++) step();
      chk("t1_busy_last", {31'd0, busy}, 32'd1);
      step();
      chk("t1_busy_fall", {31'd0, busy}, 32'd0);
      chk("t1_data_hold", {24'd0, dout}, 32'h11);

      // 2: all four requesting continuously
      do_reset();
      d0 = 8'h11; d1 = 8'h22; d2 = 8'h33; d3 = 8'h44;
      req = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         wait_send(20, n);
         if (i == 0) chk("t2_first_lat", n, 1);
         else        chk("t2_spacing", n, BC);
         chk("t2_data", {24'd0, dout}, 32'h11 * ((i % 4) + 1));
         chk("t2_ack",  {28'd0, ack},  32'd1 << (i % 4));
         chk("t2_lg",   {30'd0, lg},   i % 4);
      end

      // 3: ports 0 and 3 only
      do_reset();
      req = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         exp_port = (i % 2 == 0) ? 2'd0 : 2'd3;
         wait_send(20, n);
         chk("t3_ack",  {28'd0, ack}, 32'd1 << exp_port);
         chk("t3_lg",   {30'd0, lg},  {30'd0, exp_port});
         chk("t3_data", {24'd0, dout}, 32'h11 * (exp_port + 1));
      end

      // 4: req[2] pulsed during WAIT and withdrawn before IDLE
      do_reset();
      req = 4'b0001;
      wait_send(4, n);
      req = 4'b0000;
      step();
      step();
      req = 4'b0100;
      step();
      step();
      step();
      req = 4'b0000;
      sends = 0;
      acks  = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         if (send === 1'b1) sends++;
         if (ack !== 4'b0000) acks++;
      end
      chk("t4_no_send", sends, 0);
      chk("t4_no_ack",  acks,  0);

      // 5: reset in the uart_send cycle of a 1111 burst
      do_reset();
      req = 4'b1111;
      wait_send(4, n);
      chk("t5_ack0", {28'd0, ack}, 32'b0001);
      rst = 1'b1;
      step();
      chk("t5_send", {31'd0, send}, 32'd0);
      chk("t5_ack",  {28'd0, ack},  32'd0);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_data", {24'd0, dout}, 32'd0);
      chk("t5_lg",   {30'd0, lg},   32'd0);
      rst = 1'b0;
      wait_send(4, n);
      chk("t5_post_lat", n, 1);
      chk("t5_post_ack", {28'd0, ack}, 32'b0001);

      // 6: data1 changes while port 1 waits behind a window
      do_reset();
      d0 = 8'h11; d1 = 8'h55;
      req = 4'b0011;
      wait_send(4, n);
      chk("t6_first_ack", {28'd0, ack}, 32'b0001);
      req = 4'b0010;
      step();
      step();
      step();
      d1 = 8'h66;
      wait_send(20, n);
      chk("t6_spacing", n, BC - 3);
      chk("t6_ack",  {28'd0, ack},  32'b0010);
      chk("t6_data", {24'd0, dout}, 32'h66);
      chk("t6_lg",   {30'd0, lg},   32'd1);
      req = 4'b0000;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
